// File: rtl/ram_arbiter.sv
// Shares one external RAM bus among NUM_CH requesters and adds a per-transaction timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default is fixed priority (lowest index wins).
module ram_arbiter #(
    parameter  int NUM_CH  = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 64,
    localparam int SEL_W   = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_req_i,
    input  logic [NUM_CH-1:0]          ch_we_i,
    input  logic [NUM_CH*SEL_W-1:0]    ch_sel_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
    output logic [DATA_W-1:0]          ch_rdata_o,
    output logic [NUM_CH-1:0]          ch_ready_o,
    output logic [NUM_CH-1:0]          ch_err_o,
    output logic                       ram_ce_o,
    output logic                       ram_we_o,
    output logic [SEL_W-1:0]           ram_sel_o,
    output logic [ADDR_W-1:0]          ram_addr_o,
    output logic [DATA_W-1:0]          ram_data_o,
    input  logic [DATA_W-1:0]          ram_data_i,
    input  logic                       ram_ready_i
);

    localparam int GNT_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [GNT_W-1:0]  grant, grant_nxt, winner;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              any_req, timed_out;

    logic              ce_nxt, we_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, rdata_nxt;
    logic [NUM_CH-1:0] ready_nxt, err_nxt;

    logic [SEL_W-1:0]  sel_arr   [NUM_CH];
    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign sel_arr[k]   = ch_sel_i[k*SEL_W +: SEL_W];
        assign addr_arr[k]  = ch_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = ch_wdata_i[k*DATA_W +: DATA_W];
    end

    assign any_req   = |ch_req_i;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic [GNT_W-1:0] rr_ptr, rr_idx;

    // Scan from farthest to nearest so the channel right after rr_ptr ends up winning.
    always_comb begin
        winner = '0;
        rr_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            rr_idx = GNT_W'((int'(rr_ptr) + i) % NUM_CH);
            if (ch_req_i[rr_idx]) winner = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= GNT_W'(NUM_CH - 1);
        else if (state == IDLE && any_req)
            rr_ptr <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ch_req_i[i]) winner = GNT_W'(i);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            cnt        <= '0;
            ram_ce_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_sel_o  <= '0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            ch_rdata_o <= '0;
            ch_ready_o <= '0;
            ch_err_o   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            cnt        <= cnt_nxt;
            ram_ce_o   <= ce_nxt;
            ram_we_o   <= we_nxt;
            ram_sel_o  <= sel_nxt;
            ram_addr_o <= addr_nxt;
            ram_data_o <= wdata_nxt;
            ch_rdata_o <= rdata_nxt;
            ch_ready_o <= ready_nxt;
            ch_err_o   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (ram_ready_i || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the RAM bus is parked at zero outside BUSY.
    always_comb begin
        ce_nxt    = ram_ce_o;
        we_nxt    = ram_we_o;
        sel_nxt   = ram_sel_o;
        addr_nxt  = ram_addr_o;
        wdata_nxt = ram_data_o;
        rdata_nxt = ch_rdata_o;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        ready_nxt = '0;
        err_nxt   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    ce_nxt    = 1'b1;
                    we_nxt    = ch_we_i[winner];
                    sel_nxt   = sel_arr[winner];
                    addr_nxt  = addr_arr[winner];
                    wdata_nxt = wdata_arr[winner];
                    grant_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + 1'b1;
                if (ram_ready_i || timed_out) begin
                    ready_nxt[grant] = 1'b1;
                    err_nxt[grant]   = ~ram_ready_i;
                    rdata_nxt        = (ram_ready_i && !ram_we_o) ? ram_data_i : '0;
                    ce_nxt           = 1'b0;
                    we_nxt           = 1'b0;
                    sel_nxt          = '0;
                    addr_nxt         = '0;
                    wdata_nxt        = '0;
                end
            end
            DONE: cnt_nxt = '0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model plus directed scenarios with literal expectations.
module tb_ram_arbiter;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_CH-1:0]         ch_req_i   = '0;
    logic [NUM_CH-1:0]         ch_we_i    = '0;
    logic [NUM_CH*SEL_W-1:0]   ch_sel_i   = '0;
    logic [NUM_CH*ADDR_W-1:0]  ch_addr_i  = '0;
    logic [NUM_CH*DATA_W-1:0]  ch_wdata_i = '0;
    logic [DATA_W-1:0]         ch_rdata_o;
    logic [NUM_CH-1:0]         ch_ready_o, ch_err_o;
    logic                      ram_ce_o, ram_we_o;
    logic [SEL_W-1:0]          ram_sel_o;
    logic [ADDR_W-1:0]         ram_addr_o;
    logic [DATA_W-1:0]         ram_data_o;
    logic [DATA_W-1:0]         ram_data_i  = '0;
    logic                      ram_ready_i = 1'b0;

    ram_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_sel_i(ch_sel_i),
        .ch_addr_i(ch_addr_i), .ch_wdata_i(ch_wdata_i),
        .ch_rdata_o(ch_rdata_o), .ch_ready_o(ch_ready_o), .ch_err_o(ch_err_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level model ----------------
    int          m_ch   = -1;   // channel being served, -1 when the bus is free
    int          m_busy = 0;    // bus cycles spent on the current transaction
    bit          m_cool = 1'b0; // the pulse cycle, in which requests are not looked at
    int          m_rr   = NUM_CH - 1;
    logic        e_ce = 1'b0, e_we = 1'b0;
    logic [3:0]  e_sel = '0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic [1:0]  e_ready = '0, e_err = '0;

    function automatic int pick(input logic [NUM_CH-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= NUM_CH; i++)
            if (req[(m_rr + i) % NUM_CH]) return (m_rr + i) % NUM_CH;
`else
        for (int i = 0; i < NUM_CH; i++)
            if (req[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        e_ready = '0;
        e_err   = '0;
        if (rst) begin
            m_ch = -1; m_busy = 0; m_cool = 1'b0; m_rr = NUM_CH - 1;
            e_ce = 1'b0; e_we = 1'b0; e_sel = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_ch < 0) begin
            if (ch_req_i != '0) begin
                m_ch    = pick(ch_req_i);
                m_rr    = m_ch;
                m_busy  = 0;
                e_ce    = 1'b1;
                e_we    = ch_we_i[m_ch];
                e_sel   = ch_sel_i[m_ch*SEL_W +: SEL_W];
                e_addr  = ch_addr_i[m_ch*ADDR_W +: ADDR_W];
                e_wdata = ch_wdata_i[m_ch*DATA_W +: DATA_W];
            end
        end else begin
            m_busy++;
            if (ram_ready_i || (TIMEOUT != 0 && m_busy == TIMEOUT)) begin
                e_ready[m_ch] = 1'b1;
                e_err[m_ch]   = !ram_ready_i;
                e_rdata       = (ram_ready_i && !e_we) ? ram_data_i : 32'h0;
                m_ch   = -1;
                m_cool = 1'b1;
                e_ce   = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ce", 64'(ram_ce_o), 64'(e_ce));
        chk("ready", 64'(ch_ready_o), 64'(e_ready));
        chk("err", 64'(ch_err_o), 64'(e_err));
        chk("rdata", 64'(ch_rdata_o), 64'(e_rdata));
        if (e_ce) begin
            chk("we", 64'(ram_we_o), 64'(e_we));
            chk("sel", 64'(ram_sel_o), 64'(e_sel));
            chk("addr", 64'(ram_addr_o), 64'(e_addr));
            chk("wdata", 64'(ram_data_o), 64'(e_wdata));
        end
    endtask

    // ---------------- requesters and RAM responder ----------------
    int          rem [NUM_CH] = '{default: 0};
    int          grant_log[$];
    int          ram_wait = 0;      // bus cycles before ready; -1 = never ready
    int          ce_cycles = 0;
    logic [31:0] rd_val = '0;
    bit          stray = 1'b0;

    task automatic requester_update();
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_ready_o[k] && rem[k] > 0) begin
                grant_log.push_back(k);
                rem[k]--;
                if (rem[k] == 0) begin
                    ch_req_i[k] = 1'b0;
                end else begin
                    ch_addr_i[k*ADDR_W +: ADDR_W]  = ch_addr_i[k*ADDR_W +: ADDR_W] + 32'd4;
                    ch_wdata_i[k*DATA_W +: DATA_W] = ch_wdata_i[k*DATA_W +: DATA_W] + 32'd1;
                end
            end
        end
    endtask

    task automatic responder_update();
        if (ram_ce_o) begin
            ram_ready_i = (ram_wait >= 0) && (ce_cycles == ram_wait);
            ram_data_i  = ram_ready_i ? rd_val : 32'h0BAD_0000 + 32'(ce_cycles);
            ce_cycles++;
        end else begin
            ram_ready_i = stray;
            ram_data_i  = 32'h5555_AAAA;
            ce_cycles   = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
        requester_update();
        responder_update();
    endtask

    task automatic start(input int ch, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata, input int n);
        ch_we_i[ch]                     = we;
        ch_sel_i[ch*SEL_W +: SEL_W]     = sel;
        ch_addr_i[ch*ADDR_W +: ADDR_W]  = addr;
        ch_wdata_i[ch*DATA_W +: DATA_W] = wdata;
        rem[ch]                         = n;
        ch_req_i[ch]                    = 1'b1;
    endtask

    task automatic run_txn(output int n_ce);
        n_ce = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ram_ce_o) n_ce++;
            if (ch_ready_o != '0) return;
        end
        chk("txn_budget", 64'(ch_ready_o != '0), 64'd1);
    endtask

    int n_ce;
    int exp_order [6];

    initial begin
        repeat (3) step();
        chk_en = 1'b1;
        step();
        chk("rst_ce", 64'(ram_ce_o), 64'd0);
        chk("rst_ready", 64'(ch_ready_o), 64'd0);
        chk("rst_err", 64'(ch_err_o), 64'd0);
        chk("rst_rdata", 64'(ch_rdata_o), 64'd0);
        chk("rst_ram_bus", {ram_we_o, ram_sel_o, ram_addr_o, ram_data_o}, 64'd0);
        rst = 1'b0;
        step();

        // single 0-wait read on ch1
        ram_wait = 0; rd_val = 32'hDEAD_BEEF;
        start(1, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 1);
        step();
        chk("t1_ce", 64'(ram_ce_o), 64'd1);
        chk("t1_addr", 64'(ram_addr_o), 64'h8000_0100);
        step();
        chk("t1_ready", 64'(ch_ready_o), 64'b10);
        chk("t1_rdata", 64'(ch_rdata_o), 64'hDEAD_BEEF);
        chk("t1_ce_off", 64'(ram_ce_o), 64'd0);
        step();

        // write on ch0, RAM takes 3 wait cycles; bus must stay stable
        ram_wait = 3;
        start(0, 1'b1, 4'b0011, 32'h0000_0040, 32'h0000_1234, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_bus", {ram_ce_o, ram_we_o, ram_sel_o, ram_data_o}, {1'b1, 1'b1, 4'b0011, 32'h0000_1234});
        end
        step();
        chk("t2_ready", 64'(ch_ready_o), 64'b01);
        chk("t2_rdata", 64'(ch_rdata_o), 64'd0);
        step();

        // reset in the middle of a never-answered transaction
        ram_wait = -1;
        start(1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1);
        repeat (3) step();
        chk("t4_busy", 64'(ram_ce_o), 64'd1);
        rst = 1'b1; ch_req_i = '0; rem = '{default: 0};
        step();
        chk("t4_ce", 64'(ram_ce_o), 64'd0);
        chk("t4_ready", 64'(ch_ready_o), 64'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("t4_quiet", 64'(ch_ready_o), 64'd0);

        // both channels request continuously
        ram_wait = 0; rd_val = 32'h1111_2222;
        grant_log.delete();
        start(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 3);
        start(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 3);
        for (int i = 0; i < 80 && (rem[0] + rem[1]) != 0; i++) step();
        chk("t3_done", 64'(rem[0] + rem[1]), 64'd0);
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        chk("t3_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("t3_order", 64'(grant_log[i]), 64'(exp_order[i]));
        step();

        // RAM never answers -> timeout after TIMEOUT bus cycles
        ram_wait = -1;
        start(0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 1);
        run_txn(n_ce);
        chk("t5_ce_cycles", 64'(n_ce), 64'd8);
        chk("t5_ready", 64'(ch_ready_o), 64'b01);
        chk("t5_err", 64'(ch_err_o), 64'b01);
        chk("t5_rdata", 64'(ch_rdata_o), 64'd0);
        step();

        // ready on the last allowed cycle wins over timeout
        ram_wait = 7; rd_val = 32'hCAFE_F00D;
        start(1, 1'b0, 4'hF, 32'h0000_3100, 32'h0, 1);
        run_txn(n_ce);
        chk("t6_ce_cycles", 64'(n_ce), 64'd8);
        chk("t6_ready", 64'(ch_ready_o), 64'b10);
        chk("t6_err", 64'(ch_err_o), 64'b00);
        chk("t6_rdata", 64'(ch_rdata_o), 64'hCAFE_F00D);
        step();

        // stray ram_ready_i while idle is ignored
        stray = 1'b1;
        repeat (4) step();
        chk("t7_idle_ce", 64'(ram_ce_o), 64'd0);
        chk("t7_idle_rdata", 64'(ch_rdata_o), 64'hCAFE_F00D);
        stray = 1'b0;
        step();

        // requester drops its request mid-transaction; it still completes
        ram_wait = 4; rd_val = 32'h0F0F_0F0F;
        start(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0, 1);
        step(); step();
        ch_req_i[0] = 1'b0;
        run_txn(n_ce);
        chk("t8_ready", 64'(ch_ready_o), 64'b01);
        chk("t8_rdata", 64'(ch_rdata_o), 64'h0F0F_0F0F);
        step();

        // write on ch1 with partial byte select
        ram_wait = 1;
        start(1, 1'b1, 4'b1100, 32'h0000_5000, 32'hA5A5_5A5A, 1);
        run_txn(n_ce);
        chk("t9_ready", 64'(ch_ready_o), 64'b10);
        chk("t9_rdata", 64'(ch_rdata_o), 64'd0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
